inst_fetch_unit: RTL
====================

# inst_fetch_unit

Instruction fetch stage that sits directly upstream of the synchronous instruction RAM. It owns the program counter, drives the RAM word address, pairs each one-cycle-late RAM read with its PC, and presents instructions to decode through a valid/ready handshake. A 2-entry output buffer absorbs decode back-pressure without losing in-flight reads. A redirect port (branch/jump/exception) flushes all fetched-but-unconsumed state.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte PC fetched first after reset.
- `ADDR_W`, default 12: RAM word-address width.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `imem_addr` out ADDR_W: RAM word address = `fetch_pc[ADDR_W+1:2]`.
- `imem_rdata` in 32: RAM read data, valid the cycle after the address was driven.
- `redirect_valid` in 1: load a new PC and flush; highest priority.
- `redirect_pc` in 32: target byte PC; bits [1:0] are ignored and treated as 0.
- `inst_valid` out 1: `inst`/`inst_pc` hold a valid instruction.
- `inst_ready` in 1: decode accepts; a transfer occurs when `inst_valid && inst_ready`.
- `inst` out 32: instruction word.
- `inst_pc` out 32: byte PC of `inst`.

## Operation
- State: `pc` (next byte PC to issue), `inflight` flag plus `inflight_pc`, a 2-entry FIFO of {inst, pc}, and a `cnt` of 0..2.
- `fetch_pc` is `redirect_pc & ~3` when `redirect_valid` is high, otherwise `pc`. `imem_addr` is driven combinationally from `fetch_pc`.
- `pop` = `inst_valid && inst_ready`.
- `issue` = `redirect_valid || (cnt + inflight - pop) <= 1`.
- On issue: `inflight <= 1`, `inflight_pc <= fetch_pc`, `pc <= fetch_pc + 4` (mod 2^32).
- On no issue: `inflight <= 0` and `pc` holds. The RAM still reads `imem_addr`, but the data is discarded.
- When `inflight` is high, `imem_rdata` is paired with `inflight_pc` and pushed into the FIFO. Bypass (see Configuration) may send it straight to the output instead.
- Redirect in cycle N:
  - Flushes the FIFO (`cnt <= 0`) and kills the response arriving in N, which is not pushed.
  - Forces `inst_valid = 0` in cycle N.
  - Issues `redirect_pc` in the same cycle N.
- Push and pop in the same cycle leave `cnt` unchanged. `cnt` never exceeds 2; the issue rule guarantees this, and the bench asserts it.
- PC arithmetic is 32-bit wrap. The RAM address aliases modulo 2^ADDR_W words.
- Reset (async, any time):
  - `pc <= RESET_PC`, `inflight <= 0`, `cnt <= 0`.
  - Outputs: `inst_valid = 0`, `inst = 0`, `inst_pc = 0`.
  - `imem_addr` shows `RESET_PC[ADDR_W+1:2]` during reset.
  - Any in-flight read is dropped.

## Timing
- The first cycle with `rst_n` high is cycle 0. `RESET_PC` is issued in cycle 0, and its data appears on `imem_rdata` in cycle 1.
- Issue-to-`inst_valid` latency: 1 cycle with bypass, 2 cycles without.
- Steady-state throughput is 1 instruction/cycle while `inst_ready` is held high, in both configurations.
- Deasserting `inst_ready` loses nothing: at most one in-flight word plus two buffered words exist, and issue stops once the FIFO is committed full.
- Redirect in cycle N: the first target instruction is valid in N+1 with bypass, N+2 without. No pre-redirect instruction is ever presented after cycle N-1.
- `inst`/`inst_pc` hold stable while `inst_valid && !inst_ready`.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When `cnt == 0` and a live response arrives, `inst = imem_rdata` and `inst_pc = inflight_pc` combinationally, with `inst_valid = 1`.
  - If popped that cycle, nothing is pushed; otherwise it is pushed.
  - Adds a RAM-to-decode combinational path.
- `FETCH_BYPASS_EN` undefined:
  - Outputs come only from the FIFO head and are fully registered.
  - Adds +1 cycle latency after reset/redirect.

## Test plan
- Reset release, `RESET_PC` = 0, `inst_ready` = 1, RAM word k = k:
  - `inst_pc` sequence 0, 4, 8, … with `inst` 0, 1, 2, … back-to-back.
  - First valid in cycle 1 (bypass) or cycle 2 (no bypass).
- Back-pressure: `inst_ready` low for 5 cycles mid-stream, then high:
  - `cnt` peaks at 2.
  - Stalled output holds PC 0x10.
  - Resumed sequence 0x10, 0x14, 0x18 with no gap or duplicate.
- Redirect to 0x0000_0103 while 2 buffered + 1 in flight:
  - `inst_valid` = 0 in the redirect cycle.
  - Next presented PC = 0x100, followed by 0x104.
  - No old PC appears.
- Redirect in the same cycle as a pop, and redirect on consecutive cycles (0x40 then 0x80):
  - Only the 0x80 stream is presented.
- Async reset asserted mid-stream between edges:
  - `inst_valid`, `inst` and `inst_pc` go to 0 immediately.
  - After release, fetch restarts at `RESET_PC`.
- `pc` = 0xFFFF_FFFC:
  - Next issued PC is 0x0000_0000.
  - `imem_addr` wraps from 0xFFF to 0x000.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the sync RAM address and buffers
// fetched words in a 2-entry FIFO for decode. Define FETCH_BYPASS_EN for the RAM-to-decode bypass.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc
);

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic [31:0] fifo_inst [2];
  logic [31:0] fifo_pc   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  cnt;

  logic        live;
  logic        bypass;
  logic        pop;
  logic        fifo_pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ;

  // Stage 0: PC select and RAM address
  assign fetch_pc  = redirect_valid ? word_align(redirect_pc) : pc;
  assign imem_addr = fetch_pc[ADDR_W+1:2];

  // Stage 1: RAM response pairing, output select and handshake
  assign live = inflight && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass = live && (cnt == 2'd0);
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid = !redirect_valid && ((cnt != 2'd0) || bypass);

  always_comb begin
    inst    = 32'h0;
    inst_pc = 32'h0;
    if (bypass) begin
      inst    = imem_rdata;
      inst_pc = inflight_pc;
    end else if (cnt != 2'd0) begin
      inst    = fifo_inst[rd_ptr];
      inst_pc = fifo_pc[rd_ptr];
    end
  end

  assign pop      = inst_valid && inst_ready;
  assign fifo_pop = pop && (cnt != 2'd0);
  assign push     = live && !(bypass && pop);

  // Committed occupancy after this cycle; a new read is issued only if it is guaranteed a slot.
  assign occ   = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue = redirect_valid || (occ <= 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      cnt      <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc <= fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        cnt    <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        cnt <= cnt + {1'b0, push} - {1'b0, fifo_pop};
        if (push) begin
          wr_ptr <= ~wr_ptr;
        end
        if (fifo_pop) begin
          rd_ptr <= ~rd_ptr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      inflight_pc <= fetch_pc;
    end
    if (push) begin
      fifo_inst[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

endmodule
